// File: rtl/seq_pack_loader.sv
// Front-end loader for the banded Smith-Waterman accelerator: encodes ASCII bases,
// packs one reference/query pair, launches the engine and tracks completion/watchdog.
module seq_pack_loader #(
  parameter int L       = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           s_valid,
  input  logic [7:0]     s_data,
  input  logic           s_last,
  output logic           s_ready,
  output logic           acc_start,
  output logic [3*L-1:0] acc_r,
  output logic [3*L-1:0] acc_q,
  input  logic           acc_ready,
  output logic           busy,
  output logic           pair_done,
  output logic           overflow,
  output logic           timeout,
  output logic [7:0]     pair_count
);

  localparam int             IW    = $clog2(L + 1);
  localparam logic [IW-1:0]  L_IDX = IW'(L);
  localparam logic [9:0]     TO_V  = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_R = 3'd1,
    LOAD_Q = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [9:0]       wait_q, wait_d;
  logic             rdy_prev_q;
  logic [3*L-1:0]   acc_r_q, acc_r_d, acc_q_q, acc_q_d;
  logic             s_ready_q, s_ready_d;
  logic             acc_start_q, acc_start_d;
  logic             busy_q, busy_d;
  logic             pair_done_q, pair_done_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       pair_count_q, pair_count_d;
  logic             hs_s;
  logic [2:0]       sym_s;

  // 3'd0 is kept for padding, so unknown bytes (N and anything else) map to 3'd5.
  function automatic logic [2:0] encode_base(input logic [7:0] b);
    case (b)
      8'h41, 8'h61: encode_base = 3'd1;
      8'h43, 8'h63: encode_base = 3'd2;
      8'h47, 8'h67: encode_base = 3'd3;
      8'h54, 8'h74: encode_base = 3'd4;
      default:      encode_base = 3'd5;
    endcase
  endfunction

  // Write one symbol into the slot selected by idx, leaving other slots untouched.
  function automatic logic [3*L-1:0] put_sym(input logic [3*L-1:0] word,
                                             input logic [IW-1:0]  idx,
                                             input logic [2:0]     sym);
    logic [3*L-1:0] w;
    w = word;
    for (int i = 0; i < L; i++) begin
      if (idx == IW'(i)) begin
        w[3*i +: 3] = sym;
      end else begin
        w[3*i +: 3] = word[3*i +: 3];
      end
    end
    return w;
  endfunction

  assign sym_s = encode_base(s_data);
  assign hs_s  = s_valid & s_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    acc_r_d      = acc_r_q;
    acc_q_d      = acc_q_q;
    pair_done_d  = 1'b0;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;
    pair_count_d = pair_count_q;

    case (state_q)
      IDLE: begin
        state_d = LOAD_R;
        idx_d   = '0;
        acc_r_d = '0;
        acc_q_d = '0;
      end
      LOAD_R: begin
        if (hs_s) begin
          if (idx_q < L_IDX) begin
            acc_r_d = put_sym(acc_r_q, idx_q, sym_s);
            idx_d   = idx_q + IW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (s_last) begin
            state_d = LOAD_Q;
            idx_d   = '0;
          end else begin
            state_d = LOAD_R;
          end
        end else begin
          state_d = LOAD_R;
        end
      end
      LOAD_Q: begin
        if (hs_s) begin
          if (idx_q < L_IDX) begin
            acc_q_d = put_sym(acc_q_q, idx_q, sym_s);
            idx_d   = idx_q + IW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (s_last) begin
            state_d = START;
            idx_d   = '0;
          end else begin
            state_d = LOAD_Q;
          end
        end else begin
          state_d = LOAD_Q;
        end
      end
      START: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        // Completion is checked first so it wins over a coincident watchdog expiry.
        if (acc_ready && !rdy_prev_q) begin
          pair_done_d  = 1'b1;
          pair_count_d = pair_count_q + 8'd1;
          state_d      = IDLE;
        end else if ((wait_q + 10'd1) == TO_V) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d   = (state_d == LOAD_R) || (state_d == LOAD_Q);
    acc_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wait_q       <= '0;
      rdy_prev_q   <= 1'b0;
      acc_r_q      <= '0;
      acc_q_q      <= '0;
      s_ready_q    <= 1'b0;
      acc_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      pair_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      pair_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      rdy_prev_q   <= acc_ready;
      acc_r_q      <= acc_r_d;
      acc_q_q      <= acc_q_d;
      s_ready_q    <= s_ready_d;
      acc_start_q  <= acc_start_d;
      busy_q       <= busy_d;
      pair_done_q  <= pair_done_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign acc_start  = acc_start_q;
  assign acc_r      = acc_r_q;
  assign acc_q      = acc_q_q;
  assign busy       = busy_q;
  assign pair_done  = pair_done_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
  assign pair_count = pair_count_q;

endmodule

// File: doc/seq_pack_loader.md
Name: seq_pack_loader

Overview:
- Upstream feeder for the banded Smith-Waterman accelerator.
- Accepts a byte stream of ASCII nucleotides, encodes each base to a 3-bit symbol and packs one reference (R) and one query (Q) sequence into L-symbol words.
- Pulses the accelerator's start, then waits for its ready before accepting the next pair.
- Handles short/long sequences, completion detection and a watchdog timeout.

Parameters:
L, 8, symbols per sequence; acc_r/acc_q are 3*L bits
TIMEOUT, 1023, max cycles in WAIT before abort; 10-bit counter

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
s_valid  input  1  stream byte valid
s_data  input  8  ASCII base: A/C/G/T/N, upper or lower case
s_last  input  1  marks final byte of current sequence (R, then Q)
s_ready  output  1  loader accepts byte this cycle
acc_start  output  1  one-cycle start pulse to accelerator
acc_r  output  3*L  packed R; symbol i at bits [3i+2:3i]
acc_q  output  3*L  packed Q, same packing
acc_ready  input  1  accelerator done level (ready)
busy  output  1  high in any state except IDLE
pair_done  output  1  one-cycle pulse on accelerator completion
overflow  output  1  sticky; a sequence exceeded L symbols
timeout  output  1  sticky; WAIT exceeded TIMEOUT cycles
pair_count  output  8  completed pairs, wraps 255->0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0, including acc_r, acc_q, flags and pair_count.
  - Internal symbol index 0.
- Encoding, combinational on s_data:
  - A/a=3'd1, C/c=3'd2, G/g=3'd3, T/t=3'd4.
  - Any other byte, including N, = 3'd5.
  - 3'd0 is reserved for padding and is never produced from input.
- States:
  - IDLE: s_ready=0. Go to LOAD_R on the next cycle; clears idx and both packing registers to 0.
  - LOAD_R: s_ready=1.
    - On handshake (s_valid & s_ready), write symbol to slot idx if idx<L, else drop it and set overflow.
    - idx saturates at L.
    - Handshake with s_last: go to LOAD_Q with idx=0. Unwritten slots remain 0, so short sequences are zero-padded.
  - LOAD_Q: identical to LOAD_R but packs into acc_q. Handshake with s_last goes to START.
  - START: s_ready=0, acc_start=1 for exactly this one cycle. Go to WAIT with wait counter=0.
  - WAIT:
    - s_ready=0. Wait counter increments each cycle.
    - Completion is a rising edge of acc_ready, using a registered previous value. Any acc_ready level already high on WAIT entry is ignored until it falls.
    - On completion: pair_done=1 for one cycle, pair_count+1, go to IDLE.
    - If the counter reaches TIMEOUT first: set timeout, go to IDLE, no pair_done, pair_count unchanged.
    - If both occur in the same cycle, completion wins.
- acc_r/acc_q:
  - Registered, updated only in LOAD states.
  - Stable from START through WAIT and held in IDLE until the next LOAD_R clear.
- Latency from last Q byte handshake:
  - acc_start is high the next cycle.
  - Minimum 2 cycles from acc_ready rise to the next s_ready=1: rise → pair_done/IDLE → LOAD_R.
- s_valid with s_ready=0: the byte is not consumed; the upstream source must hold it.
- overflow/timeout stay set until reset_n.

Test Plan:
- L=8, R="ACGTACGT"+last, Q="acgtnacg"+last:
  - acc_r=24'o43214321, acc_q=24'o32154321.
  - acc_start is a single pulse the cycle after the Q last byte.
  - busy=1 throughout the pair.
- R="AC"+last, Q="G"+last:
  - acc_r=24'o00000021, acc_q=24'o00000003.
  - overflow=0.
- R of 10 bytes ("ACGTACGTGG"+last on 10th):
  - Only the first 8 are packed, and all 10 are consumed.
  - overflow=1 and stays 1 across the following pair.
- Hold acc_ready=1 on entry to WAIT, drop it, then raise it after 20 cycles:
  - Exactly one pair_done, and pair_count=1.
  - No completion fires from the initial high level.
- TIMEOUT=15 with acc_ready held 0:
  - timeout=1 after 15 WAIT cycles, then state returns to IDLE, then LOAD_R.
  - pair_done never asserts and pair_count is unchanged.
- Assert reset_n=0 mid-LOAD_Q, asynchronously between edges:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a full new pair loads correctly.
